// File: rtl/uart_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Shared types for the UART receive buffer.
//   rx_entry_t : one stored character, {error, data}
//   ENTRY_W    : width of rx_entry_t in bits
// No ports (package).
// -----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

   localparam int ENTRY_W = 9;

   typedef struct packed {
      logic       error;
      logic [7:0] data;
   } rx_entry_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// -----------------------------------------------------------------------------
// uart_fifo_ram
// 2**ADDR_W x WIDTH register array: synchronous write, asynchronous read.
// Storage is intentionally not reset; the owner masks unused entries.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module uart_fifo_ram #(
   parameter int ADDR_W = 4,
   parameter int WIDTH  = 9
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer behind the UART receiver. Captures {error, data} on the
// receiver strobe, presents the head entry show-ahead, and reports fill level,
// sticky overflow and a character-timeout indication.
// Ports:
//   clk, resetb     : clock, asynchronous active-low reset
//   clr             : synchronous flush (pointers, count, overflow, idle)
//   wr_en/wr_data/wr_error : receiver strobe, byte and error flag
//   rd_en           : pop request, honoured only when rd_valid
//   rd_valid        : FIFO not empty
//   rd_data/rd_error: head entry, 0 when empty
//   count           : stored entries, 0..2**DEPTH_LOG2
//   full            : count at maximum
//   overflow        : sticky, a write was dropped while full
//   overflow_clr    : clears overflow
//   timeout_cycles  : idle threshold, 0 disables
//   timeout         : data pending with no activity for timeout_cycles
// -----------------------------------------------------------------------------
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2    = 4,
   parameter int TIMEOUT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     resetb,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     wr_error,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [7:0]               rd_data,
   output logic                     rd_error,
   output logic [DEPTH_LOG2:0]      count,
   output logic                     full,
   output logic                     overflow,
   input  logic                     overflow_clr,
   input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
   output logic                     timeout
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]      CNT_MAX = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]      CNT_ONE = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0]    PTR_ONE = (DEPTH_LOG2)'(1);
   localparam logic [TIMEOUT_WIDTH-1:0] IDLE_ONE = (TIMEOUT_WIDTH)'(1);

   logic [DEPTH_LOG2-1:0]    wr_ptr;
   logic [DEPTH_LOG2-1:0]    rd_ptr;
   logic [DEPTH_LOG2:0]      cnt;
   logic                     ovf;
   logic [TIMEOUT_WIDTH-1:0] idle;
   logic                     tmo;

   logic      empty;
   logic      is_full;
   logic      pop;
   logic      wr_acc;
   logic      wr_drop;
   logic      activity;
   rx_entry_t wr_entry;
   rx_entry_t head_entry;

   function automatic logic [TIMEOUT_WIDTH-1:0] sat_inc(
      input logic [TIMEOUT_WIDTH-1:0] v
   );
      return (&v) ? v : v + IDLE_ONE;
   endfunction

   assign empty   = (cnt == '0);
   assign is_full = (cnt == CNT_MAX);

   // clr wins over everything: strobes in a flush cycle are discarded.
   // A pop frees a slot in the same edge, so a full FIFO still accepts a write.
   assign pop      = rd_en && !empty && !clr;
   assign wr_acc   = wr_en && !clr && (!is_full || pop);
   assign wr_drop  = wr_en && !clr && is_full && !pop;
   assign activity = wr_acc || pop || clr;

   assign wr_entry = '{error: wr_error, data: wr_data};

   uart_fifo_ram #(
      .ADDR_W (DEPTH_LOG2),
      .WIDTH  (ENTRY_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (head_entry)
   );

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_acc, pop})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: cnt <= cnt;
         endcase
      end
   end

   // Setting beats clearing so a drop in the clear cycle is never lost.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         ovf <= 1'b0;
      end else if (wr_drop) begin
         ovf <= 1'b1;
      end else if (clr || overflow_clr) begin
         ovf <= 1'b0;
      end
   end

   // The compare uses the current idle value, so timeout rises one edge after
   // idle reaches the threshold; activity forces it low on the following edge.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         idle <= '0;
         tmo  <= 1'b0;
      end else begin
         if (activity || empty) idle <= '0;
         else                   idle <= sat_inc(idle);
         tmo <= !activity && (timeout_cycles != '0) && !empty &&
                (idle >= timeout_cycles);
      end
   end

   assign rd_valid = !empty;
   assign rd_data  = empty ? 8'h00 : head_entry.data;
   assign rd_error = empty ? 1'b0  : head_entry.error;
   assign count    = cnt;
   assign full     = is_full;
   assign overflow = ovf;
   assign timeout  = tmo;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

   localparam int DL2 = 2;
   localparam int TW  = 16;

   logic          clk = 1'b0;
   logic          resetb = 1'b0;
   logic          clr = 1'b0;
   logic          wr_en = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          wr_error = 1'b0;
   logic          rd_en = 1'b0;
   logic          rd_valid;
   logic [7:0]    rd_data;
   logic          rd_error;
   logic [DL2:0]  count;
   logic          full;
   logic          overflow;
   logic          overflow_clr = 1'b0;
   logic [TW-1:0] timeout_cycles = '0;
   logic          timeout;

   int vectors = 0;
   int miscompares = 0;
   logic [8:0] exp_q [$];

   uart_rx_fifo #(.DEPTH_LOG2(DL2), .TIMEOUT_WIDTH(TW)) dut (
      .clk            (clk),
      .resetb         (resetb),
      .clr            (clr),
      .wr_en          (wr_en),
      .wr_data        (wr_data),
      .wr_error       (wr_error),
      .rd_en          (rd_en),
      .rd_valid       (rd_valid),
      .rd_data        (rd_data),
      .rd_error       (rd_error),
      .count          (count),
      .full           (full),
      .overflow       (overflow),
      .overflow_clr   (overflow_clr),
      .timeout_cycles (timeout_cycles),
      .timeout        (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every honoured pop is checked against the scoreboard head.
   always @(negedge clk) begin
      if (resetb && rd_en && rd_valid && !clr) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL pop_unexpected: got 0x%0h, required no pop", {rd_error, rd_data});
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            if ({rd_error, rd_data} !== e) begin
               miscompares++;
               $display("FAIL pop_data: got 0x%0h, required 0x%0h", {rd_error, rd_data}, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] d, input logic e, input bit stored);
      wr_en = 1'b1; wr_data = d; wr_error = e;
      if (stored) exp_q.push_back({e, d});
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic wrpop(input logic [7:0] d, input logic e);
      wr_en = 1'b1; rd_en = 1'b1; wr_data = d; wr_error = e;
      exp_q.push_back({e, d});
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd_valid"}, rd_valid, 0);
      chk({tag, "_rd_data"},  rd_data,  0);
      chk({tag, "_rd_error"}, rd_error, 0);
      chk({tag, "_count"},    count,    0);
      chk({tag, "_full"},     full,     0);
      chk({tag, "_overflow"}, overflow, 0);
      chk({tag, "_timeout"},  timeout,  0);
   endtask

   initial begin
      // Reset state
      #2;
      chk_all_zero("reset");
      tick();
      resetb = 1'b1;
      tick();

      // Two bytes, then pop them
      wr(8'h41, 1'b0, 1);
      wr(8'h42, 1'b1, 1);
      chk("two_count", count, 2);
      chk("two_valid", rd_valid, 1);
      chk("two_data", rd_data, 8'h41);
      chk("two_err", rd_error, 0);
      pop();
      chk("pop1_data", rd_data, 8'h42);
      chk("pop1_err", rd_error, 1);
      pop();
      chk("pop2_valid", rd_valid, 0);
      chk("pop2_data", rd_data, 0);

      // Fill, overflow, clear overflow
      for (int i = 0; i < 4; i++) wr(8'h10 + 8'(i), 1'b0, 1);
      chk("fill_full", full, 1);
      chk("fill_count", count, 4);
      chk("fill_ovf", overflow, 0);
      wr(8'h14, 1'b0, 0);
      chk("drop_ovf", overflow, 1);
      chk("drop_count", count, 4);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      chk("ovfclr", overflow, 0);

      // Full with simultaneous write and pop
      wrpop(8'h55, 1'b0);
      chk("wrpop_count", count, 4);
      chk("wrpop_ovf", overflow, 0);
      chk("wrpop_full", full, 1);
      for (int i = 0; i < 4; i++) pop();
      chk("drain_count", count, 0);

      // Pop on empty is ignored
      pop();
      chk("empty_pop_count", count, 0);

      // Pointer wrap
      for (int i = 0; i < 10; i++) begin
         wr(8'(i), 1'(i % 2), 1);
         chk("wrap_count1", count, 1);
         pop();
         chk("wrap_count0", count, 0);
      end

      // Timeout
      timeout_cycles = 16'd5;
      wr(8'hA5, 1'b0, 1);
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("tmo_k%0d", k), timeout, (k == 6) ? 1 : 0);
      end
      tick();
      chk("tmo_hold", timeout, 1);
      pop();
      chk("tmo_clear", timeout, 0);
      for (int k = 0; k < 8; k++) tick();
      chk("tmo_empty", timeout, 0);
      timeout_cycles = '0;
      wr(8'hB6, 1'b1, 1);
      for (int k = 0; k < 20; k++) tick();
      chk("tmo_disabled", timeout, 0);
      pop();

      // clr with stored data, overflow set and a write in the same cycle
      for (int i = 0; i < 4; i++) wr(8'h20 + 8'(i), 1'b0, 1);
      wr(8'h24, 1'b0, 0);
      pop();
      chk("pre_clr_count", count, 3);
      chk("pre_clr_ovf", overflow, 1);
      clr = 1'b1; wr_en = 1'b1; wr_data = 8'h77; wr_error = 1'b1;
      exp_q.delete();
      tick();
      clr = 1'b0; wr_en = 1'b0;
      chk("clr_count", count, 0);
      chk("clr_valid", rd_valid, 0);
      chk("clr_ovf", overflow, 0);
      wr(8'h88, 1'b0, 1);
      chk("post_clr_count", count, 1);
      chk("post_clr_data", rd_data, 8'h88);
      pop();
      chk("scoreboard_empty", exp_q.size(), 0);

      // Asynchronous reset mid-operation
      timeout_cycles = 16'd2;
      for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i), 1'b1, 0);
      for (int k = 0; k < 4; k++) tick();
      chk("pre_rst_ovf", overflow, 1);
      chk("pre_rst_tmo", timeout, 1);
      #2;
      resetb = 1'b0;
      #1;
      chk_all_zero("async_rst");
      exp_q.delete();
      tick();
      resetb = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
